// File: rtl/skew_lookup_ctrl.sv
// skew_lookup_ctrl: two-bank lookup controller with alternating insert victim and saturating hit/miss statistics
module skew_lookup_ctrl #(
    parameter int WIDTH     = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [WIDTH-1:0]     req_data_i,
    input  logic                 req_insert_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic                 resp_hit_o,
    output logic                 resp_side_o,
    output logic                 bank_read_o,
    output logic [WIDTH-1:0]     bank_data_o,
    output logic [1:0]           bank_write_o,
    input  logic [1:0]           bank_hit_i,
    input  logic                 stats_clr_i,
    output logic [CNT_WIDTH-1:0] hit_cnt_o,
    output logic [CNT_WIDTH-1:0] miss_cnt_o
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOOKUP = 2'd1;
    localparam logic [1:0] INSERT = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [WIDTH-1:0]     key_q, key_d;
    logic                 insert_q, insert_d;
    logic                 victim_q, victim_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 resp_hit_q, resp_hit_d;
    logic                 resp_side_q, resp_side_d;
    logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
    logic                 accept, lookup, any_hit, resp_done;

    always_comb begin
        accept       = state_q == IDLE && req_valid_i;
        lookup       = state_q == LOOKUP;
        any_hit      = |bank_hit_i;
        resp_done    = resp_valid_q && resp_ready_i;
        state_d      = state_q == IDLE   ? (req_valid_i ? LOOKUP : IDLE)
                     : lookup            ? ((!any_hit && insert_q) ? INSERT : RESP)
                     : state_q == INSERT ? RESP
                     : (resp_done ? IDLE : RESP);
        key_d        = accept ? req_data_i : key_q;
        insert_d     = accept ? req_insert_i : insert_q;
        victim_d     = state_q == INSERT ? ~victim_q : victim_q;
        resp_hit_d   = lookup ? any_hit : resp_hit_q;
        // left bank wins a double hit; misses report the left side unless an insert picks the victim
        resp_side_d  = lookup ? (any_hit && !bank_hit_i[0])
                     : state_q == INSERT ? victim_q : resp_side_q;
        // first RESP cycle only settles the response registers, valid rises one edge later
        resp_valid_d = state_q == RESP && !resp_done;
        hit_cnt_d    = stats_clr_i ? '0
                     : (lookup && any_hit && !(&hit_cnt_q)) ? hit_cnt_q + CNT_WIDTH'(1) : hit_cnt_q;
        miss_cnt_d   = stats_clr_i ? '0
                     : (lookup && !any_hit && !(&miss_cnt_q)) ? miss_cnt_q + CNT_WIDTH'(1) : miss_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            key_q        <= '0;
            insert_q     <= 1'b0;
            victim_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_side_q  <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            insert_q     <= insert_d;
            victim_q     <= victim_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_side_q  <= resp_side_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign req_ready_o  = state_q == IDLE;
    assign bank_read_o  = state_q == LOOKUP;
    assign bank_write_o = state_q == INSERT ? (victim_q ? 2'b10 : 2'b01) : 2'b00;
    assign bank_data_o  = key_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_hit_o   = resp_hit_q;
    assign resp_side_o  = resp_side_q;
    assign hit_cnt_o    = hit_cnt_q;
    assign miss_cnt_o   = miss_cnt_q;
endmodule

// File: tb/tb_skew_lookup_ctrl.sv
// tb_skew_lookup_ctrl: randomized bench for skew_lookup_ctrl against a transaction-level reference model
module tb_skew_lookup_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [63:0] req_data_i = '0;
    logic        req_insert_i = 1'b0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic        resp_hit_o;
    logic        resp_side_o;
    logic        bank_read_o;
    logic [63:0] bank_data_o;
    logic [1:0]  bank_write_o;
    logic [1:0]  bank_hit_i = 2'b00;
    logic        stats_clr_i = 1'b0;
    logic [15:0] hit_cnt_o;
    logic [15:0] miss_cnt_o;

    int checks = 0;
    int passed = 0;
    int exp_hit_cnt = 0;
    int exp_miss_cnt = 0;
    logic exp_victim = 1'b0;

    skew_lookup_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_data_i(req_data_i), .req_insert_i(req_insert_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_hit_o(resp_hit_o), .resp_side_o(resp_side_o),
        .bank_read_o(bank_read_o), .bank_data_o(bank_data_o),
        .bank_write_o(bank_write_o), .bank_hit_i(bank_hit_i),
        .stats_clr_i(stats_clr_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk = ~clk;

    // One full request/response transaction; expectations come from the model state, not the DUT
    task automatic run_txn(input logic [63:0] key, input logic ins, input logic [1:0] hb,
                           input int hold, input logic clr);
        logic       hit;
        logic       side;
        logic [1:0] wr;
        hit  = hb != 2'b00;
        side = hit ? !hb[0] : (ins ? exp_victim : 1'b0);
        wr   = (!hit && ins) ? (exp_victim ? 2'b10 : 2'b01) : 2'b00;
        checks++;
        if (req_ready_o !== 1'b1) $display("FAIL idle_ready got=%b want=1", req_ready_o);
        else passed++;
        req_valid_i = 1'b1; req_data_i = key; req_insert_i = ins;
        @(posedge clk); #1;
        req_valid_i = 1'b0; req_data_i = {$urandom, $urandom}; req_insert_i = 1'($urandom);
        checks++;
        if ({bank_read_o, bank_write_o, resp_valid_o, req_ready_o} !== 5'b10000 || bank_data_o !== key)
            $display("FAIL lookup rd/wr/vld/rdy got=%b want=10000 data got=%h want=%h",
                     {bank_read_o, bank_write_o, resp_valid_o, req_ready_o}, bank_data_o, key);
        else passed++;
        bank_hit_i = hb; stats_clr_i = clr;
        @(posedge clk); #1;
        bank_hit_i = 2'($urandom); stats_clr_i = 1'b0;
        if (clr) begin
            exp_hit_cnt = 0; exp_miss_cnt = 0;
        end else if (hit) exp_hit_cnt = exp_hit_cnt == 65535 ? 65535 : exp_hit_cnt + 1;
        else exp_miss_cnt = exp_miss_cnt == 65535 ? 65535 : exp_miss_cnt + 1;
        if (wr != 2'b00) begin
            checks++;
            if ({bank_read_o, bank_write_o, resp_valid_o, req_ready_o} !== {1'b0, wr, 2'b00} || bank_data_o !== key)
                $display("FAIL insert rd/wr/vld/rdy got=%b want=%b", {bank_read_o, bank_write_o, resp_valid_o, req_ready_o},
                         {1'b0, wr, 2'b00});
            else passed++;
            exp_victim = ~exp_victim;
            @(posedge clk); #1;
        end
        checks++;
        if ({bank_read_o, bank_write_o, resp_valid_o, req_ready_o} !== 5'b00000 || bank_data_o !== key)
            $display("FAIL early_resp rd/wr/vld/rdy got=%b want=00000", {bank_read_o, bank_write_o, resp_valid_o, req_ready_o});
        else passed++;
        @(posedge clk); #1;
        for (int i = 0; i <= hold; i++) begin
            checks++;
            if ({resp_valid_o, resp_hit_o, resp_side_o, req_ready_o, bank_read_o, bank_write_o} !== {1'b1, hit, side, 4'b0000}
                || bank_data_o !== key)
                $display("FAIL resp cyc=%0d vld/hit/side/rdy/rd/wr got=%b want=%b", i,
                         {resp_valid_o, resp_hit_o, resp_side_o, req_ready_o, bank_read_o, bank_write_o}, {1'b1, hit, side, 4'b0000});
            else passed++;
            if (i == hold) resp_ready_i = 1'b1;
            @(posedge clk); #1;
        end
        resp_ready_i = 1'b0;
        checks++;
        if ({resp_valid_o, req_ready_o} !== 2'b01 || hit_cnt_o !== 16'(exp_hit_cnt) || miss_cnt_o !== 16'(exp_miss_cnt))
            $display("FAIL post_resp vld/rdy got=%b want=01 hits got=%0d want=%0d misses got=%0d want=%0d",
                     {resp_valid_o, req_ready_o}, hit_cnt_o, exp_hit_cnt, miss_cnt_o, exp_miss_cnt);
        else passed++;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({req_ready_o, resp_valid_o, resp_hit_o, resp_side_o, bank_read_o, bank_write_o} !== 7'b1000000
            || bank_data_o !== 64'h0 || hit_cnt_o !== 16'h0 || miss_cnt_o !== 16'h0)
            $display("FAIL reset_state got=%b want=1000000 data=%h hits=%0d misses=%0d",
                     {req_ready_o, resp_valid_o, resp_hit_o, resp_side_o, bank_read_o, bank_write_o},
                     bank_data_o, hit_cnt_o, miss_cnt_o);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({req_ready_o, resp_valid_o, bank_read_o, bank_write_o} !== 5'b10000)
            $display("FAIL after_reset rdy/vld/rd/wr got=%b want=10000", {req_ready_o, resp_valid_o, bank_read_o, bank_write_o});
        else passed++;
    endtask

    task automatic test_miss_insert();
        run_txn(64'h1234, 1'b1, 2'b00, 0, 1'b0);
        run_txn(64'h5678, 1'b1, 2'b00, 0, 1'b0);
        run_txn(64'h9abc, 1'b1, 2'b00, 0, 1'b0);
        run_txn(64'hdef0, 1'b0, 2'b00, 0, 1'b0);
    endtask

    task automatic test_hit();
        run_txn(64'h1111, 1'b1, 2'b11, 0, 1'b0);
        run_txn(64'h2222, 1'b1, 2'b10, 0, 1'b0);
        run_txn(64'h3333, 1'b0, 2'b01, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_txn(64'hcafe_f00d, 1'b1, 2'b00, 5, 1'b0);
        run_txn(64'hbeef, 1'b0, 2'b10, 5, 1'b0);
    endtask

    task automatic test_saturation();
        force dut.hit_cnt_q = 16'hffff;
        #1;
        release dut.hit_cnt_q;
        exp_hit_cnt = 65535;
        checks++;
        if (hit_cnt_o !== 16'hffff) $display("FAIL forced_hits got=%h want=ffff", hit_cnt_o);
        else passed++;
        run_txn(64'h4444, 1'b0, 2'b01, 0, 1'b0);
        run_txn(64'h5555, 1'b0, 2'b11, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) run_txn({$urandom, $urandom}, 1'b1, i[0] ? 2'b00 : 2'b10, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_txn({$urandom, $urandom}, 1'($urandom), ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 7) == 0);
    endtask

    task automatic test_reset_mid_insert();
        req_valid_i = 1'b1; req_data_i = 64'h7777; req_insert_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0; bank_hit_i = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (bank_write_o !== (exp_victim ? 2'b10 : 2'b01))
            $display("FAIL mid_insert_write got=%b want=%b", bank_write_o, exp_victim ? 2'b10 : 2'b01);
        else passed++;
        rst = 1'b0;
        #1;
        checks++;
        if ({bank_write_o, bank_read_o, resp_valid_o, req_ready_o} !== 5'b00001 || bank_data_o !== 64'h0
            || hit_cnt_o !== 16'h0 || miss_cnt_o !== 16'h0)
            $display("FAIL reset_in_insert wr/rd/vld/rdy got=%b want=00001 data=%h", {bank_write_o, bank_read_o, resp_valid_o, req_ready_o}, bank_data_o);
        else passed++;
        exp_victim = 1'b0; exp_hit_cnt = 0; exp_miss_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({bank_write_o, resp_valid_o, req_ready_o} !== 4'b0001)
                $display("FAIL after_abort cyc=%0d wr/vld/rdy got=%b want=0001", i, {bank_write_o, resp_valid_o, req_ready_o});
            else passed++;
        end
        run_txn(64'h8888, 1'b1, 2'b00, 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_miss_insert();
        test_hit();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_random();
        test_reset_mid_insert();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/skew_lookup_ctrl.md
SKEW_LOOKUP_CTRL -- requirements
Module: skew_lookup_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 64, key width driven to both banks.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, statistics counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  1  request present.
REQ-006 SHALL have port req_ready_o  output  1  request accepted when high with req_valid_i.
REQ-007 SHALL have port req_data_i  input  WIDTH  lookup key.
REQ-008 SHALL have port req_insert_i  input  1  insert key on miss.
REQ-009 SHALL have port resp_valid_o  output  1  response present.
REQ-010 SHALL have port resp_ready_i  input  1  response consumed.
REQ-011 SHALL have port resp_hit_o  output  1  key found in a bank.
REQ-012 SHALL have port resp_side_o  output  1  bank hit or written, 0 left, 1 right.
REQ-013 SHALL have port bank_read_o  output  1  read strobe to both banks.
REQ-014 SHALL have port bank_data_o  output  WIDTH  key to both banks.
REQ-015 SHALL have port bank_write_o  output  2  write strobes, bit0 left bank, bit1 right bank.
REQ-016 SHALL have port bank_hit_i  input  2  combinational hits, bit0 left, bit1 right.
REQ-017 SHALL have port stats_clr_i  input  1  synchronous statistics clear.
REQ-018 SHALL have ports hit_cnt_o, miss_cnt_o  output  CNT_WIDTH  lookup hit and miss counts.

Function
REQ-019 SHALL implement FSM states IDLE, LOOKUP, INSERT, RESP.
REQ-020 IDLE: req_ready_o=1; on req_valid_i, SHALL latch req_data_i and req_insert_i, then go to LOOKUP.
REQ-021 req_ready_o SHALL be 0 in every state except IDLE.
REQ-022 LOOKUP: bank_read_o=1 for exactly one cycle; bank_data_o=latched key; SHALL sample bank_hit_i in that cycle.
REQ-023 bank_data_o SHALL hold the latched key from LOOKUP through RESP; 0 after reset.
REQ-024 LOOKUP with any hit -> RESP, resp_hit_o=1; resp_side_o=0 if bit0 set (left wins when both set), else 1.
REQ-025 LOOKUP, miss, insert flag=1 -> INSERT; miss, insert flag=0 -> RESP, resp_hit_o=0, resp_side_o=0.
REQ-026 INSERT: bank_write_o SHALL be one-hot for one cycle, selecting the victim bank; then go to RESP with resp_hit_o=0 and resp_side_o=victim.
REQ-027 Victim pointer: 1-bit, SHALL toggle after each INSERT; hits and non-insert misses SHALL not change it.
REQ-028 RESP: resp_valid_o=1; resp_hit_o and resp_side_o stable until resp_ready_i is high; then go to IDLE.
REQ-029 Latency: accept at edge N -> resp_valid_o high after edge N+2 on hit or non-insert miss, after edge N+3 on insert.
REQ-030 bank_read_o and bank_write_o SHALL never be asserted in the same cycle; at most one bank_write_o bit SHALL be set.
REQ-031 hit_cnt_o SHALL increment on a LOOKUP hit; miss_cnt_o SHALL increment on a LOOKUP miss; both saturate at all-ones.
REQ-032 stats_clr_i SHALL zero both counters next edge; clear SHALL win over a simultaneous increment.

Reset
REQ-033 rst low SHALL immediately set state IDLE, victim=0, counters=0, resp_valid_o=0, resp_hit_o=0, resp_side_o=0, bank_read_o=0, bank_write_o=0, bank_data_o=0.
REQ-034 req_ready_o SHALL be 1 while in IDLE after reset.
REQ-035 Reset mid-transaction SHALL discard the transaction: no write strobe issued, no response produced.

Verification
REQ-036 Key 0x1234, insert=1, bank_hit_i=00 -> bank_write_o=01 one cycle; resp hit=0 side=0 at N+3; miss_cnt=1.
REQ-037 Second miss-insert -> bank_write_o=10, side=1; third -> bank_write_o=01 (victim alternation).
REQ-038 bank_hit_i=11 in LOOKUP -> resp hit=1 side=0 at N+2; no write; hit_cnt=1.
REQ-039 resp_ready_i held low 5 cycles -> resp_valid_o and fields stable 5 cycles; req_ready_o=0 throughout.
REQ-040 Force hit_cnt to 0xFFFF, one more hit -> stays 0xFFFF; stats_clr_i with a concurrent hit -> 0x0000.
REQ-041 rst low during INSERT -> bank_write_o=00 immediately; no resp_valid_o; req_ready_o=1 after release.
